// File: rtl/proc_trace_buffer_if.sv
// Read-out port of the execution-trace buffer, with master (buffer) and
// slave (consumer) modports.
//
// Handshake: the master drives rd_valid and the rd_* payload. The slave
// drives rd_ready. An entry transfers on each rising clock edge where
// rd_valid && rd_ready. While rd_valid is high and rd_ready is low, the
// payload holds steady. When rd_valid is low, the payload has no meaning.
interface proc_trace_buffer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_inst;
  logic              rd_we;
  logic [1:0]        rd_dst;
  logic [DATA_W-1:0] rd_wdata;

  modport master (
    output rd_valid, rd_pc, rd_inst, rd_we, rd_dst, rd_wdata,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_pc, rd_inst, rd_we, rd_dst, rd_wdata,
    output rd_ready
  );
endinterface

// File: rtl/proc_trace_buffer.sv
// Execution-trace recorder for the 8-bit processor.
// While the processor runs, this block keeps the last DEPTH samples of PC,
// instruction and register-write info in a circular buffer. It also counts
// enabled cycles. When HLT is seen, the buffer freezes and is drained
// oldest-first through the rd_if valid/ready port.
// Optional feature macro: TRACE_WRITES_ONLY_EN. When it is defined, only
// register-write cycles and the HLT cycle are recorded.
module proc_trace_buffer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          reset,      // async, active-low
  input  logic                          en,
  input  logic                          clr,
  input  logic [ADDR_W-1:0]             pc_in,
  input  logic [DATA_W-1:0]             inst_in,
  input  logic                          we_reg,
  input  logic [1:0]                    reg_dst,
  input  logic [DATA_W-1:0]             reg_wdata,
  input  logic                          hlt,
  proc_trace_buffer_if.master           rd_if,
  output logic                          halted,
  output logic [$clog2(DEPTH):0]        entries,
  output logic [CNT_W-1:0]              cycle_cnt,
  output logic [1:0]                    state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PTR_W + 1;
  localparam int E_W   = ADDR_W + DATA_W + 1 + 2 + DATA_W;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0] entries_q, entries_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  logic [E_W-1:0]   mem_q [DEPTH];
  logic             wr_en;
  logic [E_W-1:0]   wr_entry;
  logic [E_W-1:0]   rd_entry;
  logic             rd_valid_c;
  logic             sample;

  // Decide whether an enabled capture cycle produces a trace entry.
`ifdef TRACE_WRITES_ONLY_EN
  assign sample = we_reg | hlt;
`else
  assign sample = 1'b1;
`endif

  assign wr_entry = {pc_in, inst_in, we_reg, reg_dst, reg_wdata};

  // Next-state logic. clr overrides everything, including an hlt in the same cycle.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    entries_d   = entries_q;
    cycle_cnt_d = cycle_cnt_q;
    wr_en       = 1'b0;
    rd_valid_c  = 1'b0;
    if (clr) begin
      state_d     = CAPTURE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      entries_d   = '0;
      cycle_cnt_d = '0;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (en) begin
            if (cycle_cnt_q != {CNT_W{1'b1}}) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            if (sample) begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
              // A full buffer drops its oldest entry, so the read side moves too.
              if (entries_q == ENT_W'(DEPTH)) rd_ptr_d  = rd_ptr_q + PTR_W'(1);
              else                            entries_d = entries_q + ENT_W'(1);
            end
            if (hlt) state_d = DRAIN;
          end
        end
        DRAIN: begin
          rd_valid_c = (entries_q != '0);
          if (!rd_valid_c) begin
            state_d = DONE;
          end else if (rd_if.rd_ready) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            entries_d = entries_q - ENT_W'(1);
            if (entries_q == ENT_W'(1)) state_d = DONE;
          end
        end
        default: ;  // DONE: hold until clr or reset
      endcase
    end
  end

  // Control registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CAPTURE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      entries_q   <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      entries_q   <= entries_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Trace storage. It has no reset because the read port is masked while rd_valid is low.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign rd_entry       = rd_valid_c ? mem_q[rd_ptr_q] : '0;
  assign rd_if.rd_valid = rd_valid_c;
  assign {rd_if.rd_pc, rd_if.rd_inst, rd_if.rd_we, rd_if.rd_dst, rd_if.rd_wdata} = rd_entry;

  assign halted    = (state_q != CAPTURE);
  assign entries   = entries_q;
  assign cycle_cnt = cycle_cnt_q;
  assign state_dbg = state_q;

endmodule
